spmv_row_acc: RTL

SPMV_ROW_ACC -- requirements
Module: spmv_row_acc

---
 rtl/spmv_row_acc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spmv_row_acc.sv
// CSR sparse-matrix/vector row accumulator: walks row pointers, sums each row's
// products into a wide accumulator and writes one saturated result per row.
module spmv_row_acc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ACC_WIDTH  = 72,
  parameter int FRAC_BITS  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          num_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  input  logic                           rb_valid,
  output logic                           rb_ready,
  input  logic [ADDR_WIDTH-1:0]          rb_data,
  input  logic                           p_valid,
  output logic                           p_ready,
  input  logic signed [2*DATA_WIDTH-1:0] p_data,
  output logic                           y_valid,
  input  logic                           y_ready,
  output logic [ADDR_WIDTH-1:0]          y_addr,
  output logic [DATA_WIDTH-1:0]          y_data
);

  typedef enum logic [2:0] {IDLE, FIRST, ROWLEN, ACC, WRITE, FIN} state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        nrows;
  logic [ADDR_WIDTH-1:0]        row;
  logic [ADDR_WIDTH-1:0]        prev;
  logic [ADDR_WIDTH-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]        len;
  logic                         rb_dec;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_sum;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> FRAC_BITS;
    if (s > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return s[DATA_WIDTH-1:0];
  endfunction

  // A decreasing row pointer is flagged and treated as an empty row.
  assign rb_dec  = rb_data < prev;
  assign len     = rb_dec ? '0 : rb_data - prev;
  assign acc_sum = acc + ACC_WIDTH'(p_data);

  // Ready/valid outputs are registered and depend only on state, so each
  // handshake below reduces to the producer/consumer side of the pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rb_ready <= 1'b0;
      p_ready  <= 1'b0;
      y_valid  <= 1'b0;
      y_addr   <= '0;
      y_data   <= '0;
      acc      <= '0;
      row      <= '0;
      nrows    <= '0;
      prev     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nrows    <= num_rows;
            err      <= 1'b0;
            row      <= '0;
            busy     <= 1'b1;
            rb_ready <= 1'b1;
            state    <= FIRST;
          end
        end
        FIRST: begin
          if (rb_valid) begin
            prev <= rb_data;
            if (nrows == '0) begin
              rb_ready <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              state <= ROWLEN;
            end
          end
        end
        ROWLEN: begin
          if (rb_valid) begin
            prev     <= rb_data;
            acc      <= '0;
            rb_ready <= 1'b0;
            if (rb_dec) err <= 1'b1;
            if (len == '0) begin
              y_valid <= 1'b1;
              y_addr  <= row;
              y_data  <= '0;
              state   <= WRITE;
            end else begin
              cnt     <= len;
              p_ready <= 1'b1;
              state   <= ACC;
            end
          end
        end
        ACC: begin
          if (p_valid) begin
            acc <= acc_sum;
            cnt <= cnt - ADDR_WIDTH'(1);
            if (cnt == ADDR_WIDTH'(1)) begin
              // Result is registered from the final sum so WRITE presents it at once.
              p_ready <= 1'b0;
              y_valid <= 1'b1;
              y_addr  <= row;
              y_data  <= sat(acc_sum);
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (row == nrows - ADDR_WIDTH'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              row      <= row + ADDR_WIDTH'(1);
              rb_ready <= 1'b1;
              state    <= ROWLEN;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
